// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing the heap memory between the
// evaluator core (port 0) and the cons allocator (port 1).
// One transaction is outstanding at a time. Each transaction latches its
// command and result, and a watchdog aborts it if the memory never answers.
//
// state | meaning
// IDLE  | no transaction; sample requests and arbitrate
// ISSUE | single-cycle memory request strobe
// WAIT  | waiting for mem_ready; watchdog counting
// DONE  | single-cycle completion pulse to the owner
`timescale 1ns/1ps
module mem_arbiter #(
    parameter int ADDR_W  = 12,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              r0_req,
    input  logic              r0_we,
    input  logic [ADDR_W-1:0] r0_addr,
    input  logic [DATA_W-1:0] r0_wdata,
    output logic              r0_grant,
    output logic              r0_done,
    output logic              r0_err,
    output logic [DATA_W-1:0] r0_rdata,
    input  logic              r1_req,
    input  logic              r1_we,
    input  logic [ADDR_W-1:0] r1_addr,
    input  logic [DATA_W-1:0] r1_wdata,
    output logic              r1_grant,
    output logic              r1_done,
    output logic              r1_err,
    output logic [DATA_W-1:0] r1_rdata,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [ADDR_W-1:0] mem_alloc_addr,
    output logic              busy,
    output logic              timeout_err
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t            state, state_nxt;
    logic              owner;
    logic              last_grant;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [15:0]       cnt;
    logic              err_q;
    logic              timeout_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;

    logic              grant_take;
    logic              grant_port;
    logic              resp_ok;
    logic              time_up;
    logic [DATA_W-1:0] result;

    // Round-robin pick: on a tie the port that did not win last time goes.
    always_comb begin
        grant_take = r0_req | r1_req;
        grant_port = 1'b0;
        if (r0_req && r1_req) begin
            grant_port = ~last_grant;
        end else if (r1_req) begin
            grant_port = 1'b1;
        end
    end

    // mem_ready only counts while a request is in flight; it beats the watchdog.
    assign resp_ok = mem_ready && ((state == ISSUE) || (state == WAIT));
    assign time_up = (state == WAIT) && !mem_ready && (cnt == 16'(TIMEOUT - 1));
    assign result  = lat_we ? DATA_W'(mem_alloc_addr) : mem_rdata;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_take) state_nxt = ISSUE;
            ISSUE:   state_nxt = mem_ready ? DONE : WAIT;
            WAIT:    if (mem_ready || time_up) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Transaction latches, watchdog counter and per-port result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner      <= 1'b0;
            last_grant <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            if (state == IDLE && grant_take) begin
                owner      <= grant_port;
                last_grant <= grant_port;
                lat_we     <= grant_port ? r1_we    : r0_we;
                lat_addr   <= grant_port ? r1_addr  : r0_addr;
                lat_wdata  <= grant_port ? r1_wdata : r0_wdata;
                err_q      <= 1'b0;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT) begin
                cnt <= cnt + 16'd1;
            end
            if (resp_ok) begin
                if (owner) begin
                    rdata1_q <= result;
                end else begin
                    rdata0_q <= result;
                end
            end
            if (time_up) begin
                err_q     <= 1'b1;
                timeout_q <= 1'b1;
            end
        end
    end

    assign busy        = (state != IDLE);
    assign r0_grant    = busy && !owner;
    assign r1_grant    = busy && owner;
    assign r0_done     = (state == DONE) && !owner;
    assign r1_done     = (state == DONE) && owner;
    assign r0_err      = r0_done && err_q;
    assign r1_err      = r1_done && err_q;
    assign r0_rdata    = rdata0_q;
    assign r1_rdata    = rdata1_q;
    assign mem_req     = (state == ISSUE);
    assign mem_we      = mem_req && lat_we;
    assign mem_addr    = lat_addr;
    assign mem_wdata   = lat_wdata;
    assign timeout_err = timeout_q;

endmodule
